// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: CPU-side byte FIFO that feeds MiniUART through a WISHBONE master.
// The drain FSM polls the UART LSR ts bit, writes one byte to DATA, then waits a
// short guard interval so the UART load/ts flags settle before the next poll.
module uart_tx_fifo #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AW       = 4,
    parameter int unsigned GUARD    = 2,
    parameter logic [2:0]  DATA_OFF = 3'b000,
    parameter logic [2:0]  LSR_OFF  = 3'b001
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [1:0]  ADD_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    input  logic        STB_I,
    input  logic        WE_I,
    output logic        ACK_O,
    output logic [2:0]  uart_add_o,
    output logic [31:0] uart_dat_o,
    output logic        uart_stb_o,
    output logic        uart_we_o,
    input  logic [31:0] uart_dat_i,
    input  logic        uart_ack_i,
    output logic        irq_o
);

    typedef enum logic [1:0] {StIdle, StPoll, StWrite, StGuard} state_t;

    localparam logic [AW:0] PtrOne = 1;

    state_t      state;
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic [7:0]  count8;
    logic [7:0]  guard_cnt;
    logic        empty;
    logic        full;
    logic        data_wr;
    logic        push;
    logic        drop;
    logic        pop;
    logic        clr_ovf;
    logic        ovf;
    logic        ie;
    logic        unused;

    // Only the low byte, the W1C bit and the ie bit of CPU data and LSR bit 5 matter.
    assign unused = ^{DAT_I[31:8], uart_dat_i[31:6], uart_dat_i[4:0]};

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count   = wr_ptr - rd_ptr;
    assign count8  = 8'(count);

    // Full is taken from the pre-edge pointers, so a pop cannot rescue a push while full.
    assign data_wr = STB_I & WE_I & (ADD_I == 2'd0);
    assign push    = data_wr & ~full;
    assign drop    = data_wr & full;
    assign clr_ovf = STB_I & WE_I & (ADD_I == 2'd1) & DAT_I[2];
    assign pop     = (state == StWrite) & uart_ack_i;

    assign ACK_O   = STB_I;
    assign irq_o   = ie & empty & (state == StIdle);

    // CPU read mux; DATA and the spare offset read as zero.
    always_comb begin
        DAT_O = '0;
        case (ADD_I)
            2'd1:    DAT_O = {16'b0, count8, 5'b0, ovf, full, empty};
            2'd2:    DAT_O = {31'b0, ie};
            default: DAT_O = '0;
        endcase
    end

    // FIFO storage; no reset needed since contents are qualified by the pointers.
    always_ff @(posedge CLK_I) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= DAT_I[7:0];
        end
    end

    // Pointers, sticky overflow (set beats clear) and interrupt enable.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
            ie     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrOne;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrOne;
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
            if (STB_I && WE_I && (ADD_I == 2'd2)) begin
                ie <= DAT_I[0];
            end
        end
    end

    // Drain FSM with registered bus outputs so the UART sees glitch-free strobes.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state      <= StIdle;
            guard_cnt  <= '0;
            uart_stb_o <= 1'b0;
            uart_we_o  <= 1'b0;
            uart_add_o <= '0;
            uart_dat_o <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (!empty) begin
                        state      <= StPoll;
                        uart_stb_o <= 1'b1;
                        uart_we_o  <= 1'b0;
                        uart_add_o <= LSR_OFF;
                    end
                end
                StPoll: begin
                    if (uart_ack_i && uart_dat_i[5]) begin
                        state      <= StWrite;
                        uart_we_o  <= 1'b1;
                        uart_add_o <= DATA_OFF;
                        uart_dat_o <= {24'b0, mem[rd_ptr[AW-1:0]]};
                    end
                end
                StWrite: begin
                    if (uart_ack_i) begin
                        state      <= StGuard;
                        guard_cnt  <= 8'(GUARD - 1);
                        uart_stb_o <= 1'b0;
                        uart_we_o  <= 1'b0;
                        uart_add_o <= '0;
                        uart_dat_o <= '0;
                    end
                end
                StGuard: begin
                    if (guard_cnt == 8'd0) begin
                        state <= StIdle;
                    end else begin
                        guard_cnt <= guard_cnt - 8'd1;
                    end
                end
            endcase
        end
    end

endmodule
